// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment codes, FSM states and BCD sizing shared by the display blocks
package seg_pkg;

    // Active-low patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LATCH
    } state_t;

    // ceil(data_w * log10(2)) + 1 decimal digits, in fixed point
    function automatic int calc_nb(input int data_w);
        return (data_w * 30103 + 99999) / 100000 + 1;
    endfunction

    function automatic logic [6:0] seg_pol(input logic [6:0] pattern, input int active_low);
        return (active_low != 0) ? pattern : ~pattern;
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// rtl/seg_bcd_decode.sv - one BCD digit plus blank flag to a seven-segment pattern
module seg_bcd_decode
    import seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] pattern;

    always_comb begin
        pattern = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_BLANK;
            endcase
        end
        seg_o = seg_pol(pattern, SEG_ACTIVE_LOW);
    end

endmodule

// File: rtl/seg_bcd_display.sv
// rtl/seg_bcd_display.sv - binary to seven-segment display with sequential double-dabble conversion
module seg_bcd_display
    import seg_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DIGITS         = 5,
    parameter int SIGNED_EN      = 1,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic [7*DIGITS-1:0]   out_seg,
    output logic [6:0]            out_sign,
    output logic                  out_ovf,
    output logic                  out_done
);

    localparam int NB = calc_nb(DATA_W);
    localparam int NW = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [6:0] BLANK_P = seg_pol(SEG_BLANK, SEG_ACTIVE_LOW);
    localparam logic [6:0] DASH_P  = seg_pol(SEG_DASH, SEG_ACTIVE_LOW);

    state_t                state_q, state_d;
    logic [4*NB-1:0]       bcd_q, bcd_d;
    logic [DATA_W-1:0]     mag_q, mag_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d;
    logic [6:0]            sign_q, sign_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [4*NB-1:0]       bcd_adj;
    logic [4*NW-1:0]       bcd_wide;
    logic [DIGITS-1:0]     blank;
    logic                  ovf;
    logic                  zero_run;
    logic [7*DIGITS-1:0]   dec_seg;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digits beyond NB are always zero; the widened view covers DIGITS > NB
    always_comb begin
        bcd_wide = '0;
        bcd_wide[4*NB-1:0] = bcd_q;
        ovf = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (i >= DIGITS && bcd_wide[4*i +: 4] != 4'd0) begin
                ovf = 1'b1;
            end
        end
        zero_run = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (bcd_wide[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg_bcd_decode #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .bcd_i  (bcd_wide[4*g +: 4]),
            .blank_i(blank[g]),
            .seg_o  (dec_seg[7*g +: 7])
        );
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        seg_d    = seg_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    neg_d   = (SIGNED_EN != 0) && in_data[DATA_W-1];
                    mag_d   = neg_d ? DATA_W'(~in_data + 1'b1) : in_data;
                    bcd_d   = '0;
                    cnt_d   = CW'(DATA_W);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                seg_d   = ovf ? {DIGITS{DASH_P}} : dec_seg;
                sign_d  = (neg_q && bcd_q != '0) ? DASH_P : BLANK_P;
                ovf_d   = ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            seg_q   <= {DIGITS{BLANK_P}};
            sign_q  <= BLANK_P;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            seg_q   <= seg_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out_seg  = seg_q;
    assign out_sign = sign_q;
    assign out_ovf  = ovf_q;
    assign out_done = done_q;

endmodule

// File: tb/tb_seg_bcd_display.sv
// tb/tb_seg_bcd_display.sv - self-checking bench for seg_bcd_display across three configurations
module tb_seg_bcd_display;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  iv;
    logic [15:0] id [3];
    logic [2:0]  rdy, dn, ov;
    logic [6:0]  sg [3];
    logic [34:0] seg0, seg1;
    logic [20:0] seg2;

    int errors = 0;
    int checks = 0;

    // 0: defaults (signed), 1: unsigned, 2: unsigned with 3 digits
    seg_bcd_display u_def (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
        .out_seg(seg0), .out_sign(sg[0]), .out_ovf(ov[0]), .out_done(dn[0])
    );
    seg_bcd_display #(.SIGNED_EN(0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
        .out_seg(seg1), .out_sign(sg[1]), .out_ovf(ov[1]), .out_done(dn[1])
    );
    seg_bcd_display #(.DIGITS(3), .SIGNED_EN(0)) u_ovf (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(id[2]),
        .out_seg(seg2), .out_sign(sg[2]), .out_ovf(ov[2]), .out_done(dn[2])
    );

    function automatic logic [34:0] seg_of(input int k);
        case (k)
            0:       return seg0;
            1:       return seg1;
            default: return {14'h0, seg2};
        endcase
    endfunction

    function automatic logic [6:0] code7(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int ndig_of(input int k);
        return (k == 2) ? 3 : 5;
    endfunction

    function automatic int ref_mag(input int k, input logic [15:0] d);
        return (k == 0 && d[15]) ? 65536 - int'(d) : int'(d);
    endfunction

    function automatic int ref_lim(input int ndig);
        int lim = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        return lim;
    endfunction

    // Decimal digits by arithmetic; a digit blanks when the whole value is below its weight
    function automatic logic [34:0] ref_seg(input int ndig, input int mag);
        logic [34:0] r = '0;
        int p = 1;
        for (int i = 0; i < ndig; i++) begin
            if (mag >= ref_lim(ndig))      r[7*i +: 7] = 7'h3F;
            else if (i > 0 && mag < p)     r[7*i +: 7] = 7'h7F;
            else                           r[7*i +: 7] = code7((mag / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic convert(input int k, input logic [15:0] d, output int lat);
        lat = -1;
        @(negedge clk);
        id[k] = d;
        iv[k] = 1'b1;
        for (int w = 0; w < 40 && !rdy[k]; w++) @(negedge clk);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (dn[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv  = '0;
        for (int k = 0; k < 3; k++) id[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [34:0] exp_blank;
            exp_blank = (k == 2) ? 35'h1F_FFFF : 35'h7_FFFF_FFFF;
            checks++;
            if (seg_of(k) !== exp_blank) begin
                errors++; $display("FAIL reset_seg[%0d] got=%h exp=%h", k, seg_of(k), exp_blank);
            end
            checks++;
            if (sg[k] !== 7'h7F || rdy[k] !== 1'b1 || dn[k] !== 1'b0 || ov[k] !== 1'b0) begin
                errors++; $display("FAIL reset_ctl[%0d] got sign=%h rdy=%b done=%b ovf=%b exp 7f/1/0/0",
                                   k, sg[k], rdy[k], dn[k], ov[k]);
            end
        end
    endtask

    task automatic test_unsigned_255();
        int lat;
        logic [34:0] exp;
        exp = {7'h7F, 7'h7F, 7'h24, 7'h12, 7'h12};
        convert(1, 16'd255, lat);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL u255_latency got=%0d exp=17", lat); end
        checks++;
        if (seg1 !== exp) begin errors++; $display("FAIL u255_seg got=%h exp=%h", seg1, exp); end
        checks++;
        if (ov[1] !== 1'b0 || sg[1] !== 7'h7F) begin
            errors++; $display("FAIL u255_flags got ovf=%b sign=%h exp 0/7f", ov[1], sg[1]);
        end
    endtask

    task automatic test_zero_sign();
        logic [15:0] vals [3];
        logic [34:0] exps [3];
        logic [6:0]  sgns [3];
        int lat;
        vals[0] = 16'h0000; exps[0] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}; sgns[0] = 7'h7F;
        vals[1] = 16'hFF80; exps[1] = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h00}; sgns[1] = 7'h3F;
        vals[2] = 16'h8000; exps[2] = {7'h30, 7'h24, 7'h78, 7'h02, 7'h00}; sgns[2] = 7'h3F;
        for (int t = 0; t < 3; t++) begin
            convert(0, vals[t], lat);
            checks++;
            if (lat !== 17 || seg0 !== exps[t]) begin
                errors++; $display("FAIL sign_seg[%h] got=%h lat=%0d exp=%h lat=17", vals[t], seg0, lat, exps[t]);
            end
            checks++;
            if (sg[0] !== sgns[t] || ov[0] !== 1'b0) begin
                errors++; $display("FAIL sign_flag[%h] got sign=%h ovf=%b exp %h/0", vals[t], sg[0], ov[0], sgns[t]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        convert(2, 16'd999, lat);
        checks++;
        if (seg2 !== {7'h10, 7'h10, 7'h10} || ov[2] !== 1'b0 || lat !== 17) begin
            errors++; $display("FAIL ovf_999 got seg=%h ovf=%b lat=%0d exp=101010_ovf0", seg2, ov[2], lat);
        end
        convert(2, 16'd1000, lat);
        checks++;
        if (seg2 !== {7'h3F, 7'h3F, 7'h3F} || ov[2] !== 1'b1 || lat !== 17) begin
            errors++; $display("FAIL ovf_1000 got seg=%h ovf=%b lat=%0d exp=3f3f3f_ovf1", seg2, ov[2], lat);
        end
    endtask

    task automatic test_random();
        int lat, mag, nd;
        logic [15:0] d;
        for (int k = 0; k < 3; k++) begin
            nd = ndig_of(k);
            for (int n = 0; n < 10; n++) begin
                d = (k == 2) ? 16'($urandom_range(0, 1500)) : 16'($urandom);
                mag = ref_mag(k, d);
                convert(k, d, lat);
                checks++;
                if (lat !== 17 || seg_of(k) !== ref_seg(nd, mag)) begin
                    errors++; $display("FAIL rand_seg[%0d] in=%h got=%h lat=%0d exp=%h lat=17",
                                       k, d, seg_of(k), lat, ref_seg(nd, mag));
                end
                checks++;
                if (sg[k] !== ((k == 0 && d[15]) ? 7'h3F : 7'h7F) || ov[k] !== (mag >= ref_lim(nd))) begin
                    errors++; $display("FAIL rand_flag[%0d] in=%h got sign=%h ovf=%b", k, d, sg[k], ov[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        int got;
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        id[0] = a;
        iv[0] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            got = -1;
            for (int c = 1; c <= 40; c++) begin
                #1;
                if (c > 1 && dn[0]) begin
                    got = c - 1;
                    break;
                end
                checks++;
                if (rdy[0] !== 1'b0) begin
                    errors++; $display("FAIL bp_ready pass=%0d cyc=%0d got=%b exp=0", pass, c, rdy[0]);
                end
                id[0] = 16'($urandom);
                @(posedge clk);
            end
            checks++;
            if (got !== 17 || seg0 !== ref_seg(5, ref_mag(0, pass == 0 ? a : b))) begin
                errors++; $display("FAIL bp_value pass=%0d got=%h lat=%0d exp=%h lat=17",
                                   pass, seg0, got, ref_seg(5, ref_mag(0, pass == 0 ? a : b)));
            end
            checks++;
            if (rdy[0] !== 1'b1) begin
                errors++; $display("FAIL bp_idle_ready pass=%0d got=%b exp=1", pass, rdy[0]);
            end
            id[0] = b;
            if (pass == 1) iv[0] = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit  seen_done = 1'b0;
        @(negedge clk);
        id[0] = 16'd1234;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (seg0 !== 35'h7_FFFF_FFFF || sg[0] !== 7'h7F || ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_state got seg=%h sign=%h ovf=%b rdy=%b exp blank/7f/0/1",
                               seg0, sg[0], ov[0], rdy[0]);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (dn[0]) seen_done = 1'b1;
        end
        checks++;
        if (seen_done || seg0 !== 35'h7_FFFF_FFFF) begin
            errors++; $display("FAIL midrst_nodone got done_seen=%b seg=%h exp 0/blank", seen_done, seg0);
        end
        convert(0, 16'd42, lat);
        checks++;
        if (lat !== 17 || seg0 !== {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}) begin
            errors++; $display("FAIL midrst_42 got=%h lat=%0d exp=%h lat=17", seg0, lat,
                               {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_255();
        test_zero_sign();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
